l1_mem_arbiter: RTL
===================

// Module: l1_mem_arbiter
// PURPOSE
//  Shares the single 128-bit line memory port between the L1 I-cache (line refill reads) and the
//  L1 D-cache (line refill reads and dirty-line write-backs). One transaction outstanding at a time.
//  Round-robin arbitration; request fields registered at grant; per-transaction watchdog timeout.
//  Sits between both L1 cache controllers and the memory model.
// PARAMETERS
//  ADDR_WIDTH      8    line address width (same as cache_pkg::ADDR_WIDTH)
//  DATA_WIDTH_M    128  memory line width in bits; wmask width = DATA_WIDTH_M/8
//  TIMEOUT_CYCLES  64   max BUSY cycles before abort; 0 disables watchdog
// PORTS
//  clk            in   1        clock, all logic on rising edge
//  rst_n          in   1        synchronous active-low reset
//  i_req_valid    in   1        I-cache read request; held until i_resp_valid
//  i_req_addr     in   ADDR_W   I-cache line address
//  i_resp_valid   out  1        1-cycle pulse: I transaction complete
//  i_resp_rdata   out  DATA_M   read line; valid only with i_resp_valid
//  i_resp_err     out  1        with i_resp_valid: transaction timed out
//  d_req_valid    in   1        D-cache request; held, fields stable, until d_resp_valid
//  d_req_write    in   1        1 = write-back, 0 = refill read
//  d_req_addr     in   ADDR_W   D-cache line address
//  d_req_wdata    in   DATA_M   write-back line
//  d_req_wmask    in   DATA_M/8 write byte mask
//  d_resp_valid   out  1        1-cycle pulse: D transaction complete
//  d_resp_rdata   out  DATA_M   read line (0 for writes); valid only with d_resp_valid
//  d_resp_err     out  1        with d_resp_valid: transaction timed out
//  mem_req_valid  out  1        held high for whole BUSY phase
//  mem_req_write  out  1        1 = write
//  mem_req_addr   out  ADDR_W   registered line address
//  mem_req_wdata  out  DATA_M   registered write data (0 for reads)
//  mem_req_wmask  out  DATA_M/8 registered mask (0 for reads)
//  mem_resp_valid in   1        1-cycle pulse: memory completed current request
//  mem_resp_rdata in   DATA_M   read data, valid with mem_resp_valid
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, last_grant=D, timer=0, every output 0. Reset mid-transaction
//   abandons it: no resp pulse; a mem_resp_valid arriving afterwards in IDLE/DONE is ignored.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: if any req_valid, pick owner, latch addr/write/wdata/wmask (reads force wdata=0, wmask=0),
//    go BUSY. Neither -> stay IDLE.
//   Arbitration when both valid: owner = requester NOT equal to last_grant (reset -> I-cache wins first).
//    Single requester always wins. last_grant updated on every grant.
//   BUSY: mem_req_* driven from registers. mem_resp_valid=1 -> latch rdata (0 if write), err=0, go DONE.
//    Else timer++; timer reaching TIMEOUT_CYCLES (non-zero) -> rdata=0, err=1, go DONE.
//   DONE: owner's resp_valid=1 for exactly this cycle, with rdata/err; mem_req_valid=0; -> IDLE.
//    Non-owner resp_valid=0. Requester deasserts req_valid in the cycle after resp_valid.
//  Timing: req in IDLE at cycle N -> mem_req_valid=1 at N+1; mem_resp_valid at M -> resp_valid at M+1,
//   IDLE at M+2; earliest next mem_req_valid at M+3. mem_resp_valid in same cycle as grant is ignored.
//  Timer: $clog2(TIMEOUT_CYCLES+1) bits, cleared on grant, never wraps. TIMEOUT_CYCLES=0 -> wait forever.
//  req_valid or fields changing while BUSY do not affect the in-flight transaction (registered copy).
//  resp_rdata/resp_err hold their last value outside the pulse; consumers sample only with resp_valid.
// TESTING
//  1 I read alone: i_req addr=0x14; mem_resp at 3rd BUSY cycle rdata=0xA5..A5 -> i_resp_valid 1 cycle,
//    rdata=0xA5..A5, err=0; mem_req_write=0, wmask=0.
//  2 D write-back: d_req write=1 addr=0x3C wdata=0x1122..FF wmask=0xFFFF -> mem_req_* match exactly,
//    d_resp_valid pulse with rdata=0, err=0.
//  3 Simultaneous I and D after reset -> I granted first, D granted at the next IDLE; repeat with both
//    still valid -> grants alternate I,D,I,D across 4 transactions.
//  4 Timeout: TIMEOUT_CYCLES=4, D read, no mem_resp -> mem_req_valid high 4 cycles, then d_resp_valid
//    with err=1, rdata=0; late mem_resp_valid 3 cycles later produces no resp pulse.
//  5 Reset mid-BUSY: assert rst_n=0 on 2nd BUSY cycle -> next cycle all outputs 0, no resp pulse;
//    stray mem_resp_valid after release ignored; next I request completes normally.
//  6 Stability: change d_req_addr 0x10->0x20 during BUSY -> mem_req_addr stays 0x10 until DONE.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: round-robin sharing of one line memory port between the L1 I-cache and D-cache,
// one transaction in flight, request fields captured at grant, optional per-transaction watchdog.
module l1_mem_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH_M   = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr_i,
  output logic                      i_resp_valid_o,
  output logic [DATA_WIDTH_M-1:0]   i_resp_rdata_o,
  output logic                      i_resp_err_o,
  input  logic                      d_req_valid_i,
  input  logic                      d_req_write_i,
  input  logic [ADDR_WIDTH-1:0]     d_req_addr_i,
  input  logic [DATA_WIDTH_M-1:0]   d_req_wdata_i,
  input  logic [DATA_WIDTH_M/8-1:0] d_req_wmask_i,
  output logic                      d_resp_valid_o,
  output logic [DATA_WIDTH_M-1:0]   d_resp_rdata_o,
  output logic                      d_resp_err_o,
  output logic                      mem_req_valid_o,
  output logic                      mem_req_write_o,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
  output logic [DATA_WIDTH_M-1:0]   mem_req_wdata_o,
  output logic [DATA_WIDTH_M/8-1:0] mem_req_wmask_o,
  input  logic                      mem_resp_valid_i,
  input  logic [DATA_WIDTH_M-1:0]   mem_resp_rdata_i
);
  localparam int MW = DATA_WIDTH_M / 8;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                  state_q, state_d;
  logic                    last_d_q, last_d_d, own_d_q, own_d_d, write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH_M-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [MW-1:0]           wmask_q, wmask_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    i_err_q, i_err_d, d_err_q, d_err_d;
  logic                    pick_d, timeout, finish, rsp_err;
  logic [DATA_WIDTH_M-1:0] rsp_rdata;
  // D wins only when alone or when I was the last one served
  assign pick_d    = d_req_valid_i && (!i_req_valid_i || !last_d_q);
  assign timeout   = TIMEOUT_CYCLES != 0 && timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign finish    = mem_resp_valid_i || timeout;
  assign rsp_err   = !mem_resp_valid_i;
  assign rsp_rdata = (mem_resp_valid_i && !write_q) ? mem_resp_rdata_i : '0;
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    own_d_d   = own_d_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    timer_d   = timer_q;
    i_rdata_d = i_rdata_q;
    i_err_d   = i_err_q;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    if (state_q == IDLE && (i_req_valid_i || d_req_valid_i)) begin
      state_d  = BUSY;
      own_d_d  = pick_d;
      last_d_d = pick_d;
      write_d  = pick_d && d_req_write_i;
      addr_d   = pick_d ? d_req_addr_i : i_req_addr_i;
      wdata_d  = write_d ? d_req_wdata_i : '0;
      wmask_d  = write_d ? d_req_wmask_i : '0;
      timer_d  = '0;
    end else if (state_q == BUSY && finish) begin
      state_d   = DONE;
      i_rdata_d = own_d_q ? i_rdata_q : rsp_rdata;
      i_err_d   = own_d_q ? i_err_q : rsp_err;
      d_rdata_d = own_d_q ? rsp_rdata : d_rdata_q;
      d_err_d   = own_d_q ? rsp_err : d_err_q;
    end else if (state_q == BUSY) begin
      timer_d = timer_q == '1 ? timer_q : timer_q + 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      own_d_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      timer_q   <= '0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      own_d_q   <= own_d_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      timer_q   <= timer_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end
  assign mem_req_valid_o = state_q == BUSY;
  assign mem_req_write_o = write_q;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;
  assign i_resp_valid_o  = state_q == DONE && !own_d_q;
  assign d_resp_valid_o  = state_q == DONE && own_d_q;
  assign i_resp_rdata_o  = i_rdata_q;
  assign i_resp_err_o    = i_err_q;
  assign d_resp_rdata_o  = d_rdata_q;
  assign d_resp_err_o    = d_err_q;
endmodule
